// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver states, channel codes and word size.
// Both ends of the I2S link import this package.
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } i2s_state_e;

   localparam logic CH_LEFT       = 1'b0;
   localparam logic CH_RIGHT      = 1'b1;
   localparam int   I2S_WORD_BITS = 32;

endpackage

// File: rtl/i2s_ws_edge.sv
// Word-select sampler: previous lr_clk sample, post-reset priming,
// and slot-edge / new-channel outputs.
module i2s_ws_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_lr_clk,
   output logic o_ws_edge,
   output logic o_chan
);

   logic r_ws_q;
   logic r_primed;

   // First cycle after reset only loads ws_q so a high lr_clk is no edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ws_q   <= 1'b0;
         r_primed <= 1'b0;
      end else begin
         r_ws_q   <= i_lr_clk;
         r_primed <= 1'b1;
      end
   end

   assign o_ws_edge = r_primed && (i_lr_clk != r_ws_q);
   assign o_chan    = i_lr_clk;

endmodule

// File: rtl/i2s_receiver.sv
// I2S serial-to-parallel receiver: MSB-first slots with 1-bit delay,
// per-word and per-frame outputs with single-cycle strobes.
module i2s_receiver
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = I2S_WORD_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lr_clk,
   input  logic                  sd_in,
   output logic [DATA_WIDTH-1:0] word_data,
   output logic                  word_right,
   output logic                  word_valid,
   output logic [DATA_WIDTH-1:0] frame_left,
   output logic [DATA_WIDTH-1:0] frame_right,
   output logic                  frame_valid,
   output logic                  frame_err
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

   i2s_state_e r_state;
   i2s_state_e w_state_nxt;

   logic [DATA_WIDTH-2:0] r_shift;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_chan;
   logic                  r_left_pending;
   logic [DATA_WIDTH-1:0] r_left_hold;

   logic [DATA_WIDTH-1:0] r_word_data;
   logic                  r_word_right;
   logic                  r_word_valid;
   logic [DATA_WIDTH-1:0] r_frame_left;
   logic [DATA_WIDTH-1:0] r_frame_right;
   logic                  r_frame_valid;
   logic                  r_frame_err;

   logic                  w_ws_edge;
   logic                  w_chan;
   logic                  w_start;
   logic                  w_shift;
   logic                  w_lsb;
   logic                  w_short;
   logic [DATA_WIDTH-1:0] w_word_nxt;

   i2s_ws_edge u_ws_edge (
      .clk       (clk),
      .rst       (rst),
      .i_lr_clk  (lr_clk),
      .o_ws_edge (w_ws_edge),
      .o_chan    (w_chan)
   );

   assign w_word_nxt = {r_shift, sd_in};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_lsb       = 1'b0;
      w_short     = 1'b0;
      unique case (r_state)
         ST_INIT: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT, ST_HOLD: begin
            if (w_ws_edge) begin
               w_state_nxt = ST_SHIFT;
               w_start     = 1'b1;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == LAST) begin
               // Exact-length slot: next edge lands on the LSB cycle
               w_lsb = 1'b1;
               if (w_ws_edge) begin
                  w_start = 1'b1;
               end else begin
                  w_state_nxt = ST_HOLD;
               end
            end else if (w_ws_edge) begin
               w_shift = 1'b0;
               w_short = 1'b1;
               w_start = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift        <= '0;
         r_cnt          <= '0;
         r_chan         <= CH_LEFT;
         r_left_pending <= 1'b0;
         r_left_hold    <= '0;
         r_word_data    <= '0;
         r_word_right   <= 1'b0;
         r_word_valid   <= 1'b0;
         r_frame_left   <= '0;
         r_frame_right  <= '0;
         r_frame_valid  <= 1'b0;
         r_frame_err    <= 1'b0;
      end else begin
         r_word_valid  <= w_lsb;
         r_frame_err   <= w_short;
         r_frame_valid <= 1'b0;
         if (w_shift) begin
            r_shift <= w_word_nxt[DATA_WIDTH-2:0];
         end
         if (w_start) begin
            r_cnt  <= '0;
            r_chan <= w_chan;
         end else if (w_shift) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_lsb) begin
            r_word_data  <= w_word_nxt;
            r_word_right <= r_chan;
            if (r_chan == CH_RIGHT) begin
               if (r_left_pending) begin
                  r_frame_left   <= r_left_hold;
                  r_frame_right  <= w_word_nxt;
                  r_frame_valid  <= 1'b1;
                  r_left_pending <= 1'b0;
               end
            end else begin
               r_left_hold    <= w_word_nxt;
               r_left_pending <= 1'b1;
            end
         end
         if (w_short) begin
            r_left_pending <= 1'b0;
         end
      end
   end

   assign word_data   = r_word_data;
   assign word_right  = r_word_right;
   assign word_valid  = r_word_valid;
   assign frame_left  = r_frame_left;
   assign frame_right = r_frame_right;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
Serial-to-parallel receiver for the team's I2S link. It is the far end of i2s_bus: it recovers 32-bit sign-extended beamformer and CIC words from the serial stream.
- Samples word select (lr_clk) and serial data (sd_in) on the system clock, which is also the bit clock.
- Deserialises each slot MSB-first.
- Presents per-word and per-stereo-frame parallel outputs with single-cycle strobes.
- Intended for loopback verification of i2s_out / cic_out and for boards that receive SuperMic audio.

Parameters:
- DATA_WIDTH, 32, bits captured per slot, MSB-first.
- CNT_W, $clog2(DATA_WIDTH), width of the bit counter (derived, not overridden).

Ports:
- clk, input, 1: system/bit clock; all sampling on its rising edge.
- rst, input, 1: asynchronous reset, active-low (asserted when 0).
- lr_clk, input, 1: word select, synchronous to clk; 0 = left slot, 1 = right slot.
- sd_in, input, 1: serial data.
- word_data, output, DATA_WIDTH: last completed word.
- word_right, output, 1: channel of word_data (1 = right).
- word_valid, output, 1: 1-cycle strobe, word_data/word_right updated.
- frame_left, output, DATA_WIDTH: left word of last complete frame.
- frame_right, output, DATA_WIDTH: right word of last complete frame.
- frame_valid, output, 1: 1-cycle strobe, frame_left/frame_right updated.
- frame_err, output, 1: 1-cycle strobe, short slot detected.

Behaviour:
- Reset (rst=0, async): all outputs 0, shift register 0, counter 0, left_pending 0, state INIT.
- Sampling: ws_q holds the previous lr_clk sample. An edge occurs when lr_clk != ws_q. The new channel is the sampled lr_clk value.
- Timing convention, standard I2S with 1-bit delay:
  - Edge at rising edge k ⇒ MSB sampled at k+1, LSB at k+DATA_WIDTH.
  - Next slot's edge is allowed no earlier than k+DATA_WIDTH.
- States:
  - INIT: one cycle after reset release; loads ws_q, no edge detection → WAIT. Prevents a spurious edge when lr_clk=1 at reset release.
  - WAIT: discards data until the first edge → SHIFT, cnt=0, chan=lr_clk.
  - SHIFT: each cycle, shift <= {shift[DATA_WIDTH-2:0], sd_in}, cnt++.
    - When cnt==DATA_WIDTH-1 (LSB this cycle): word_data <= {shift[DATA_WIDTH-2:0], sd_in}, word_right <= chan, word_valid=1.
    - After the LSB: → HOLD, unless an edge occurs in the same cycle (see simultaneous case).
  - HOLD: ignores surplus bits of a long slot (legal, no error). On edge → SHIFT, cnt=0, chan=lr_clk.
- Simultaneous LSB and edge (slot exactly DATA_WIDTH, the i2s_bus case): complete the word, then restart SHIFT with cnt=0 and the new channel. No idle cycle, no error.
- Short slot: edge in SHIFT with cnt<DATA_WIDTH-1.
  - Partial word dropped, frame_err=1 for one cycle, no word_valid.
  - left_pending cleared; restart SHIFT with cnt=0 and the new channel.
- Frame pairing:
  - Left completion sets left_pending and stores left_hold.
  - Right completion with left_pending=1: frame_left <= left_hold, frame_right <= word, frame_valid=1, left_pending cleared.
  - Right completion with left_pending=0: word_valid only, no frame_valid.
- Latency:
  - word_valid/word_data are registered, visible the cycle after the LSB sampling edge.
  - frame_valid coincides with the right word_valid.
- Strobes are never asserted for more than one consecutive cycle per event.
- Reset mid-word: immediate clear. Capture resumes only after INIT, then a fresh edge.
- Data is stored raw; no sign manipulation; sign extension is the transmitter's responsibility.

Decomposition:
- Shared package i2s_pkg: state encoding (INIT, WAIT, SHIFT, HOLD), channel constants CH_LEFT=0 / CH_RIGHT=1, default I2S_WORD_BITS=32. i2s_bus adopts the same package.
- One sub-module, i2s_ws_edge: holds ws_q, the INIT priming, and the edge/channel outputs.
- The shift/count FSM stays in i2s_receiver.

Test Plan:
- Back-to-back frames, slot 32, lr_clk period 64: left 0x8000_0001, right 0x7FFF_FFFE → word_valid twice; frame_valid with frame_left=0x80000001, frame_right=0x7FFFFFFE; no frame_err.
- Reset released with lr_clk=1 mid-slot → no strobe until the first real edge; the first complete left/right pair is captured correctly.
- Short slot: edge after 20 bits of a left word → one frame_err pulse, no word_valid; next frame 0x12345678/0x9ABCDEF0 correct.
- Long slot: 40 bits per slot (period 80), extra 8 bits random → words exact, no frame_err.
- rst pulsed low after 10 bits of a right word → outputs 0 immediately; recovery yields a correct next full frame.
- Loopback from i2s_bus sending 22-bit sum -5 (sign-extended) → word_data=0xFFFFFFFB; sum +3 → 0x00000003.
